// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel counters, active-video flag, delayed syncs,
// frame-start strobe and a free-running frame counter for game pacing.
module vga_timing_gen #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 1,
  parameter int SYNC_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        pixel_tick,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_ON  = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_OFF = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_ON  = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_OFF = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [15:0] frame_cnt;
  logic        tick;
  logic        hs_raw;
  logic        vs_raw;

  // With a 2x clock the tick lands on the second cycle after reset release.
  generate
    if (CLK_DIV == 2) begin : g_div2
      logic toggle;
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) toggle <= 1'b0;
        else       toggle <= ~toggle;
      end
      assign tick = toggle & ~reset;
    end else begin : g_div1
      assign tick = ~reset;
    end
  endgenerate

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (tick) begin
      if (hc == H_LAST) begin
        hc <= '0;
        if (vc == V_LAST) begin
          vc        <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          vc <= vc + 10'd1;
        end
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Coordinates and blank are undelayed; drawers align them with their own pipeline.
  assign DrawX       = hc;
  assign DrawY       = vc;
  assign frame_count = frame_cnt;
  assign pixel_tick  = tick;
  assign blank       = ~reset & (hc < H_VIS_C) & (vc < V_VIS_C);
  assign frame_start = tick & (hc == 10'd0) & (vc == 10'd0) & ~reset;

  assign hs_raw = ~((hc >= H_SYNC_ON) && (hc < H_SYNC_OFF));
  assign vs_raw = ~((vc >= V_SYNC_ON) && (vc < V_SYNC_OFF));

  // Sync delay stage boundary: pipes preload with 1 so no stale pulse survives reset.
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hs = hs_raw | reset;
      assign vs = vs_raw | reset;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else if (tick) begin
          hs_pipe <= (hs_pipe << 1) | SYNC_DELAY'(hs_raw);
          vs_pipe <= (vs_pipe << 1) | SYNC_DELAY'(vs_raw);
        end
      end
      assign hs = hs_pipe[SYNC_DELAY-1];
      assign vs = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (1x clock with 2-tick sync delay, and
// 2x clock with no delay) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int A_HV = 640, A_HF = 16, A_HW = 96, A_HB = 48;
  localparam int A_VV = 8,   A_VF = 2,  A_VW = 2,  A_VB = 3;
  localparam int B_HV = 8,   B_HF = 2,  B_HW = 3,  B_HB = 3;
  localparam int B_VV = 4,   B_VF = 1,  B_VW = 1,  B_VB = 2;

  typedef struct {
    int x; int y; bit blank; bit tick; bit hs; bit vs; bit fs; int fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [9:0] ax, ay, bx, by;
  logic a_blank, a_tick, a_hs, a_vs, a_fs, b_blank, b_tick, b_hs, b_vs, b_fs;
  logic [15:0] a_fc, b_fc;
  logic [15:0] fbase_b = 16'd0;
  int ca = 0, cb = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_VIS(A_HV), .H_FP(A_HF), .H_SYNC(A_HW), .H_BP(A_HB),
                   .V_VIS(A_VV), .V_FP(A_VF), .V_SYNC(A_VW), .V_BP(A_VB),
                   .CLK_DIV(1), .SYNC_DELAY(2)) dut_a (
    .vga_clk(clk), .reset(rst_a), .DrawX(ax), .DrawY(ay), .blank(a_blank),
    .pixel_tick(a_tick), .hs(a_hs), .vs(a_vs), .frame_start(a_fs), .frame_count(a_fc));

  vga_timing_gen #(.H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HW), .H_BP(B_HB),
                   .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VW), .V_BP(B_VB),
                   .CLK_DIV(2), .SYNC_DELAY(0)) dut_b (
    .vga_clk(clk), .reset(rst_b), .DrawX(bx), .DrawY(by), .blank(b_blank),
    .pixel_tick(b_tick), .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .frame_count(b_fc));

  // Cycles elapsed since each reset release.
  always @(posedge clk or posedge rst_a) if (rst_a) ca <= 0; else ca <= ca + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) cb <= 0; else cb <= cb + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Raster position is (ticks elapsed) mod frame length; syncs look back dly ticks.
  function automatic exp_t model(input int c, input int div, input int dly,
                                 input int hv, input int hf, input int hw, input int hb,
                                 input int vv, input int vf, input int vw, input int vb,
                                 input logic [15:0] fbase);
    exp_t e;
    int ht, vt, ft, n, p, hx, hy;
    logic [15:0] f;
    ht = hv + hf + hw + hb;
    vt = vv + vf + vw + vb;
    ft = ht * vt;
    n  = c / div;
    e.tick  = (div == 1) || (c % 2 == 1);
    p       = n % ft;
    e.x     = p % ht;
    e.y     = p / ht;
    e.blank = (e.x < hv) && (e.y < vv);
    e.fs    = e.tick && (p == 0);
    f       = fbase + 16'(n / ft);
    e.fc    = int'(f);
    if (n < dly) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      p    = (n - dly) % ft;
      hx   = p % ht;
      hy   = p / ht;
      e.hs = !(hx >= hv + hf && hx < hv + hf + hw);
      e.vs = !(hy >= vv + vf && hy < vv + vf + vw);
    end
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.x = 0; e.y = 0; e.blank = 0; e.tick = 0; e.hs = 1; e.vs = 1; e.fs = 0; e.fc = 0;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                     input logic bl, input logic tk, input logic h, input logic v,
                     input logic fs, input logic [15:0] fc);
    chk({tag, ".DrawX"}, x, e.x);
    chk({tag, ".DrawY"}, y, e.y);
    chk({tag, ".blank"}, bl, e.blank);
    chk({tag, ".pixel_tick"}, tk, e.tick);
    chk({tag, ".hs"}, h, e.hs);
    chk({tag, ".vs"}, v, e.vs);
    chk({tag, ".frame_start"}, fs, e.fs);
    chk({tag, ".frame_count"}, fc, e.fc);
  endtask

  always @(negedge clk) begin : compare
    exp_t ea, eb;
    ea = rst_a ? reset_exp() : model(ca, 1, 2, A_HV, A_HF, A_HW, A_HB, A_VV, A_VF, A_VW, A_VB, 16'd0);
    eb = rst_b ? reset_exp() : model(cb, 2, 0, B_HV, B_HF, B_HW, B_HB, B_VV, B_VF, B_VW, B_VB, fbase_b);
    cmp("a", ea, ax, ay, a_blank, a_tick, a_hs, a_vs, a_fs, a_fc);
    cmp("b", eb, bx, by, b_blank, b_tick, b_hs, b_vs, b_fs, b_fc);
  end

  task automatic wait_a(input int x, input int y, input int limit, input string name);
    bit hit = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (ax == 10'(x) && ay == 10'(y)) begin hit = 1; break; end
    end
    chk({"reach_", name}, hit, 1);
  endtask

  task automatic wait_b_fc(input logic [15:0] v, input int limit, input string name);
    bit hit = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (b_fc == v) begin hit = 1; break; end
    end
    chk({"reach_", name}, hit, 1);
  endtask

  initial begin
    int vs_low, first_x, first_y, early;
    vs_low = 0; first_x = -1; first_y = -1; early = 0;
    repeat (3) @(negedge clk);
    chk("rst_hs", a_hs, 1);
    chk("rst_vs", a_vs, 1);
    chk("rst_blank", a_blank, 0);
    chk("rst_tick", a_tick, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_fc", a_fc, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    fork
      begin
        @(negedge clk);
        chk("a_first_x", ax, 0);
        chk("a_first_fs", a_fs, 1);
        chk("a_first_blank", a_blank, 1);
        @(negedge clk);
        chk("a_second_x", ax, 1);
        chk("a_second_fs", a_fs, 0);
        wait_a(639, 0, 800, "x639");
        chk("blank_639", a_blank, 1);
        @(negedge clk);
        chk("blank_640", a_blank, 0);
        wait_a(657, 0, 800, "x657");
        chk("hs_657", a_hs, 1);
        @(negedge clk);
        chk("hs_658", a_hs, 0);
        wait_a(753, 0, 800, "x753");
        chk("hs_753", a_hs, 0);
        @(negedge clk);
        chk("hs_754", a_hs, 1);
        wait_a(799, 0, 800, "x799");
        @(negedge clk);
        chk("wrap_x", ax, 0);
        chk("wrap_y", ay, 1);
        for (int k = 0; k < 13000 && ca < 12000; k++) begin
          @(negedge clk);
          if (a_vs == 1'b0) begin
            if (first_x < 0) begin first_x = int'(ax); first_y = int'(ay); end
            vs_low++;
          end
        end
        chk("frame_cycles", ca, 12000);
        chk("vs_low_cycles", vs_low, 1600);
        chk("vs_first_x", first_x, 2);
        chk("vs_first_y", first_y, 10);
        chk("frame1_fc", a_fc, 1);
        chk("frame1_fs", a_fs, 1);
        chk("frame1_x", ax, 0);
        wait_a(700, 11, 13000, "x700y11");
        chk("pre_rst_hs", a_hs, 0);
        chk("pre_rst_vs", a_vs, 0);
        #1 rst_a = 1'b1;
        #1;
        chk("async_hs", a_hs, 1);
        chk("async_vs", a_vs, 1);
        chk("async_x", ax, 0);
        chk("async_y", ay, 0);
        chk("async_blank", a_blank, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_a = 1'b0;
        for (int k = 0; k < 1000; k++) begin
          @(negedge clk);
          if (ax == 10'd658 && ay == 10'd0) break;
          if (a_hs == 1'b0 || a_vs == 1'b0) early++;
        end
        chk("no_partial_sync", early, 0);
        chk("resume_hs_658", a_hs, 0);
        chk("resume_x", ax, 658);
      end
      begin
        @(negedge clk);
        chk("b_tick0", b_tick, 0);
        chk("b_fs0", b_fs, 0);
        @(negedge clk);
        chk("b_tick1", b_tick, 1);
        chk("b_fs1", b_fs, 1);
        chk("b_x_hold", bx, 0);
        @(negedge clk);
        chk("b_tick2", b_tick, 0);
        chk("b_x1", bx, 1);
        @(posedge clk); #1;
        force dut_b.frame_cnt = 16'hFFFF;
        #1 release dut_b.frame_cnt;
        fbase_b = 16'hFFFF - 16'((cb / 2) / 128);
        @(negedge clk);
        chk("b_fc_forced", b_fc, 65535);
        wait_b_fc(16'd0, 600, "b_fc_wrap");
        chk("b_wrap_x", bx, 0);
        chk("b_wrap_y", by, 0);
        wait_b_fc(16'd1, 600, "b_fc_after_wrap");
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA display path.
- Produces the DrawX/DrawY pixel coordinates and the active-video `blank` flag consumed by every ROM/palette drawer.
- Produces hsync/vsync, delayed to line up with the drawers' RGB output pipeline.
- Also supplies a frame-start strobe and a frame counter for game-logic pacing.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 1, pixel tick divider; legal values 1 or 2 (2 = run from a 2x clock)
- SYNC_DELAY, 2, pipeline stages (ticks) applied to hs/vs; matches ROM read + output register latency; legal 0..4

Ports:
- vga_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- DrawX  out  10  current horizontal count (hc), 0..H_TOT-1
- DrawY  out  10  current vertical count (vc), 0..V_TOT-1
- blank  out  1  1 = active video (hc<H_VIS and vc<V_VIS); 0 elsewhere and while reset=1
- pixel_tick  out  1  1 on cycles where the counters advance at the next edge
- hs  out  1  horizontal sync, active-low, delayed SYNC_DELAY ticks
- vs  out  1  vertical sync, active-low, delayed SYNC_DELAY ticks
- frame_start  out  1  one-cycle pulse on the tick cycle where hc=0, vc=0
- frame_count  out  16  completed-frame count

Behaviour:
- Derived totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
- Reset (async, immediate):
  - hc=0, vc=0, divider toggle=0, frame_count=0.
  - All hs/vs delay stages =1, so hs=1 and vs=1.
  - blank forced 0; frame_start=0.
- Tick generation:
  - CLK_DIV=1: pixel_tick=1 every cycle (forced 0 during reset).
  - CLK_DIV=2: toggle flips every cycle; pixel_tick = toggle. The first tick is the second cycle after reset release.
- Counters (update on vga_clk rising edge when pixel_tick=1):
  - If hc==H_TOT-1: hc←0; then if vc==V_TOT-1, vc←0 and frame_count←frame_count+1 (wraps 65535→0); else vc←vc+1.
  - Otherwise hc←hc+1.
  - Counters hold between ticks.
- DrawX=hc and DrawY=vc are driven straight from the counter registers. No added latency: drawers see coordinates the cycle the counter holds them.
- blank is a combinational decode of hc/vc gated by ~reset. It is deliberately NOT delayed, because drawers sample it alongside their own pipeline.
- Raw sync (combinational from counters):
  - hs_raw=0 iff H_VIS+H_FP ≤ hc < H_VIS+H_FP+H_SYNC, i.e. hc 656..751.
  - vs_raw=0 iff V_VIS+V_FP ≤ vc < V_VIS+V_FP+V_SYNC, i.e. vc 490..491.
  - vs_raw is full-line based and ignores hc.
- Sync delay:
  - hs/vs each pass through a SYNC_DELAY-deep shift register that shifts only on pixel_tick.
  - SYNC_DELAY=0: hs=hs_raw, vs=vs_raw (combinational, still forced 1 during reset).
- frame_start = pixel_tick & (hc==0) & (vc==0) & ~reset. High for exactly one vga_clk cycle per frame, including the first frame after reset.
- Reset mid-frame: counters snap to 0 asynchronously; delay pipes refill with 1; no partial sync pulse may be emitted after release.
- Non-display region: DrawX/DrawY continue counting through the porches and sync (values ≥640 / ≥480 are legal outputs); drawers rely on blank=0 there.

Test Plan:
- Reset then release, CLK_DIV=1, SYNC_DELAY=2:
  - frame_start=1 on the first cycle after release.
  - DrawX sequence 0,1,2…; blank=1 at DrawX=0..639 and DrawY=0; blank=0 at DrawX=640.
- Run one full line: hc wraps 799→0 and DrawY increments 0→1 on the same edge. hs first goes 0 two cycles after DrawX=656 and returns to 1 two cycles after DrawX=752 (96 cycles low).
- Run a full frame (420000 cycles):
  - vs low for exactly 1600 cycles (2 lines), starting 2 cycles after (DrawX=0, DrawY=490).
  - frame_count=1 and frame_start pulses again at cycle 420000.
- CLK_DIV=2:
  - pixel_tick alternates 0,1 after reset.
  - DrawX holds each value for 2 vga_clk cycles.
  - A full frame takes 840000 cycles; frame_start stays 1-cycle wide.
- Assert reset at DrawX=700, DrawY=491 (hs and vs both low in the pipe):
  - hs, vs, DrawX, DrawY and blank go to 1,1,0,0,0 immediately, without waiting for a clock.
  - After release, no sync low until DrawX=656 of line 0.
- Force frame_count to 65535 via a long run or bench backdoor: the next frame wrap gives 0; counting continues unaffected.
